// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter: FSM encoding,
// the double-dabble correction threshold and the digit-count sizing helper.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] ADD3_THRESHOLD = 4'd5;

  // Smallest digit count n such that 10^n exceeds the largest WIDTH-bit value.
  function automatic int min_ndig(input int width);
    logic [63:0] max_val;
    logic [63:0] pow10;
    int          n;
    max_val = (64'd1 << width) - 64'd1;
    pow10   = 64'd1;
    n       = 0;
    for (int i = 0; i < 20; i++) begin
      if (pow10 <= max_val) begin
        pow10 = pow10 * 64'd10;
        n     = n + 1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// One BCD digit corrector: adds 3 to a digit of 5 or more so that the
// following left shift produces a correct decimal carry.
module bcd_add3
  import bin2bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] fixed
);

  // Per-digit correction, no carry out of the nibble.
  always_comb begin
    fixed = digit;
    if (digit >= ADD3_THRESHOLD) begin
      fixed = digit + 4'd3;
    end else begin
      fixed = digit;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock, with
// valid/ready handshakes on the binary input and the BCD result.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NDIG  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    bin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*NDIG-1:0]   bcd,
  output logic                busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int TOT_W = 4*NDIG + WIDTH;

  generate
    if (WIDTH < 4 || WIDTH > 16 || NDIG < min_ndig(WIDTH)) begin : g_bad_params
      $fatal(1, "bin2bcd_seq: NDIG too small for WIDTH, or WIDTH outside 4..16");
    end
  endgenerate

  state_t             state;
  logic [WIDTH-1:0]   bin_sh;
  logic [CNT_W-1:0]   cnt;
  logic [4*NDIG-1:0]  corr;
  logic [TOT_W-1:0]   shifted;

  generate
    for (genvar d = 0; d < NDIG; d++) begin : g_dig
      bcd_add3 u_add3 (
        .digit (bcd[4*d +: 4]),
        .fixed (corr[4*d +: 4])
      );
    end
  endgenerate

  // Corrected digits and remaining binary bits move left together; the bit
  // dropped off the top is always zero given the digit-count constraint.
  assign shifted = {corr, bin_sh} << 1'd1;

  // Only IDLE accepts, and never while reset is held.
  assign in_ready = rst_n & (state == IDLE);

  // Conversion FSM with registered result and status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      bin_sh    <= '0;
      bcd       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            bin_sh <= bin;
            bcd    <= '0;
            cnt    <= CNT_W'(WIDTH - 1);
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          bcd    <= shifted[TOT_W-1:WIDTH];
          bin_sh <= shifted[WIDTH-1:0];
          if (cnt == '0) begin
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq (WIDTH=8, NDIG=3).
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  bin;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] bcd;
  logic        busy;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  bin2bcd_seq #(.WIDTH(8), .NDIG(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd       (bcd),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_in_ready(input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    if (!in_ready) check({tag, "_in_ready_timeout"}, 32'(in_ready), 32'd1);
  endtask

  // Accept val, measure latency and busy length, check result, handshake out.
  task automatic convert(input logic [7:0] val, input logic [11:0] exp, input string tag);
    int lat;
    int busy_n;
    wait_in_ready(tag);
    bin      = val;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat      = 0;
    busy_n   = 0;
    while (!out_valid && lat < 20) begin
      if (busy) busy_n++;
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd8);
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'd8);
    check({tag, "_bcd"}, 32'(bcd), 32'(exp));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int          n;
    int          prev_acc;
    logic [11:0] exp_bcd;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    bin       = 8'd0;
    repeat (3) tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_bcd", 32'(bcd), 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    convert(8'd0,   12'h000, "zero");
    convert(8'd255, 12'h255, "max");
    convert(8'd100, 12'h100, "hundred");
    convert(8'd99,  12'h099, "ninety_nine");

    // Back-pressure: result must hold while the consumer stalls.
    wait_in_ready("bp");
    bin      = 8'd173;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check("bp_latency", 32'(n), 32'd8);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_bcd", 32'(bcd), 32'h173);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);

    // Input activity during SHIFT and DONE is ignored.
    bin      = 8'd200;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      bin      = 8'd42;
      in_valid = ~in_valid;
      check("busy_in_ready", 32'(in_ready), 32'd0);
      tick();
      n++;
    end
    check("busy_latency", 32'(n), 32'd8);
    in_valid = 1'b1;
    tick();
    check("done_in_ready", 32'(in_ready), 32'd0);
    check("busy_bcd", 32'(bcd), 32'h200);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    check("no_accept_42_busy", 32'(busy), 32'd0);
    check("no_accept_42_ready", 32'(in_ready), 32'd1);

    // Reset on the 4th SHIFT cycle discards the conversion.
    bin      = 8'd187;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("mid_busy_before_rst", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_bcd", 32'(bcd), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    tick();
    check("mid_rel_in_ready", 32'(in_ready), 32'd1);
    convert(8'd187, 12'h187, "after_rst");

    // Exhaustive sweep with both handshakes tied high.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    prev_acc  = 0;
    for (int v = 0; v < 256; v++) begin
      wait_in_ready("sweep");
      bin = 8'(v);
      if (v > 0) check("sweep_spacing", 32'(cyc - prev_acc), 32'd10);
      prev_acc = cyc;
      tick();
      n = 0;
      while (!out_valid && n < 30) begin
        tick();
        n++;
      end
      exp_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      check("sweep_bcd", 32'(bcd), 32'(exp_bcd));
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
